// File: rtl/uart.sv
// 8N1 UART transceiver on the LPC clock: TX serialiser and RX deserialiser.
// Define UART_PARITY_EN to add an even-parity bit after data bit 7 on both paths.
module uart #(
    parameter int DIVISOR = 289
) (
    input  logic       lpc_clk,
    input  logic       lpc_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`endif

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_byte;
    logic        valid_prev;
    logic        tx_bit_end;
    logic        tx_accept;

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_accept  = tx_data_valid && !valid_prev && !tx_busy;

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_byte    <= '0;
            // Set to 1 so a valid already high when reset releases is not a rising edge.
            valid_prev <= 1'b1;
            tx_busy    <= 1'b0;
            uart_tx    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            valid_prev <= tx_data_valid;
            tx_cnt     <= tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_accept) begin
                        tx_byte  <= tx_data;
                        tx_state <= TX_START;
                        tx_busy  <= 1'b1;
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: if (tx_bit_end) begin
                    tx_state <= TX_DATA;
                    tx_idx   <= '0;
                    uart_tx  <= tx_byte[0];
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state <= TX_PARITY;
                        uart_tx  <= ^tx_byte;
`else
                        tx_state <= TX_STOP;
                        uart_tx  <= 1'b1;
`endif
                    end else begin
                        tx_idx  <= tx_idx + 3'd1;
                        uart_tx <= tx_byte[tx_idx + 3'd1];
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: if (tx_bit_end) begin
                    tx_state <= TX_STOP;
                    uart_tx  <= 1'b1;
                end
`endif
                TX_STOP: if (tx_bit_end) begin
                    tx_state <= TX_IDLE;
                    tx_busy  <= 1'b0;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    rx_state_t   rx_state;
    logic [1:0]  rx_sync;
    logic        rx_line;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_bit_end;
`ifdef UART_PARITY_EN
    logic        rx_par_ok;
`endif

    assign rx_line    = rx_sync[1];
    assign rx_bit_end = (rx_cnt == BIT_LAST);

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            rx_sync       <= 2'b11;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok     <= 1'b0;
`endif
        end else begin
            rx_sync       <= {rx_sync[0], uart_rx};
            rx_data_valid <= 1'b0;
            rx_cnt        <= rx_cnt + 16'd1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_line) rx_state <= RX_START;
                end
                // Re-check the start bit at mid-bit so short glitches are rejected.
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (!rx_line) begin
                        rx_state <= RX_DATA;
                        rx_idx   <= '0;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: if (rx_bit_end) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_line, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state <= RX_PARITY;
`else
                        rx_state <= RX_STOP;
`endif
                    end else begin
                        rx_idx <= rx_idx + 3'd1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (rx_bit_end) begin
                    rx_cnt    <= '0;
                    rx_par_ok <= (rx_line == ^rx_shift);
                    rx_state  <= RX_STOP;
                end
`endif
                RX_STOP: if (rx_bit_end) begin
                    rx_cnt <= '0;
                    if (rx_line) begin
                        rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
                        if (rx_par_ok) begin
                            rx_data       <= rx_shift;
                            rx_data_valid <= 1'b1;
                        end
`else
                        rx_data       <= rx_shift;
                        rx_data_valid <= 1'b1;
`endif
                    end else begin
                        rx_state <= RX_WAIT_HIGH;
                    end
                end
                // A held break must return high before another start bit is accepted.
                RX_WAIT_HIGH: begin
                    rx_cnt <= '0;
                    if (rx_line) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: waveform-level TX model, frame-level RX scoreboard.
// Honours UART_PARITY_EN the same way the design does.
module tb_uart;

    localparam int D = 8;
`ifdef UART_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       lpc_clk = 1'b0;
    logic       lpc_rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       uart_rx = 1'b1;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       uart_tx;

    uart #(.DIVISOR(D)) dut (
        .lpc_clk(lpc_clk),
        .lpc_rst(lpc_rst),
        .tx_data(tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 lpc_clk = ~lpc_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge lpc_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole line-level frame, bit 0 = start bit.
    function automatic logic [NB-1:0] make_frame(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // TX model: a frame is a fixed waveform of NB*D cycles started by an accepted rising edge.
    logic          m_prev = 1'b1;
    int            m_rem = 0;
    logic [NB-1:0] m_frame = '1;
    logic          exp_tx;

    always @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            m_prev = 1'b1;
            m_rem  = 0;
        end else begin
            if (m_rem > 0) m_rem--;
            else if (tx_data_valid && !m_prev) begin
                m_frame = make_frame(tx_data);
                m_rem   = NB * D;
            end
            m_prev = tx_data_valid;
        end
    end

    // RX scoreboard: each good frame expects one pulse near its stop-bit sample time.
    typedef struct {
        logic [7:0] b;
        int         due;
    } rx_exp_t;
    rx_exp_t    rxq[$];
    logic [7:0] m_rx_last = 8'h00;

    always @(negedge lpc_clk) begin
        rx_exp_t e;
        exp_tx = 1'b1;
        if (m_rem > 0) exp_tx = m_frame[(NB * D - m_rem) / D];
        check("tx_busy", tx_busy, m_rem > 0);
        check("uart_tx", uart_tx, exp_tx);
        if (rx_data_valid === 1'b1) begin
            if (rxq.size() == 0) begin
                check("rx_spurious_pulse", 1, 0);
            end else begin
                e = rxq.pop_front();
                check("rx_pulse_timing", (cyc >= e.due - 2) && (cyc <= e.due + 2), 1);
                m_rx_last = e.b;
            end
        end else if (rxq.size() > 0 && cyc > rxq[0].due + 2) begin
            check("rx_missing_pulse", 0, 1);
            void'(rxq.pop_front());
        end
        check("rx_data", rx_data, m_rx_last);
    end

    task automatic send_tx(input logic [7:0] b, input int hold);
        @(posedge lpc_clk); #1;
        tx_data       = b;
        tx_data_valid = 1'b1;
        repeat (hold) @(posedge lpc_clk);
        #1 tx_data_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3 * NB * D) begin
            @(posedge lpc_clk); #1;
            n++;
        end
        check("tx_idle_timeout", tx_busy, 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_bit, input bit par_flip);
        logic [NB-1:0] f;
        int c0;
        f = make_frame(b);
        f[NB-1] = stop_bit;
        if (PAR && par_flip) f[NB-2] = ~f[NB-2];
        @(posedge lpc_clk); #1;
        c0 = cyc;
        if (stop_bit && !(PAR && par_flip)) rxq.push_back('{b, c0 + 3 + D / 2 + (NB - 1) * D});
        for (int i = 0; i < NB; i++) begin
            uart_rx = f[i];
            repeat (D) @(posedge lpc_clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] pat;
        logic [NB-1:0] seen;
        int busy_cnt;
        int bc;

        repeat (3) @(posedge lpc_clk);
        #1;
        check("reset_uart_tx", uart_tx, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_data_valid, 0);
        lpc_rst = 1'b0;
        repeat (3) @(posedge lpc_clk);

        // 0x55 frame with a 3-cycle valid pulse, pinned against literal bit values.
`ifdef UART_PARITY_EN
        pat = 11'b10010101010;
`else
        pat = 10'b1010101010;
`endif
        @(posedge lpc_clk); #1;
        tx_data = 8'h55;
        tx_data_valid = 1'b1;
        busy_cnt = 0;
        seen = '0;
        for (int i = 0; i < NB * D + 6; i++) begin
            @(negedge lpc_clk);
            if (i == 3) tx_data_valid = 1'b0;
            busy_cnt += int'(tx_busy);
            for (int k = 0; k < NB; k++)
                if (i == 1 + k * D + D / 2) seen[k] = uart_tx;
        end
        for (int k = 0; k < NB; k++) check($sformatf("lit_0x55_bit%0d", k), seen[k], pat[k]);
        check("lit_busy_cycles", busy_cnt, PAR ? 88 : 80);

        // Rising edge while busy is dropped; the next edge after idle is sent.
        send_tx(8'h41, 1);
        repeat (20) @(posedge lpc_clk);
        send_tx(8'hA3, 5);
        wait_tx_idle();
        repeat (4) @(posedge lpc_clk);
        send_tx(8'hA3, 1);
        wait_tx_idle();

        // Plain RX frame, literal result.
        send_rx(8'h3C, 1'b1, 1'b0);
        repeat (6) @(posedge lpc_clk); #1;
        check("lit_rx_0x3c", rx_data, 8'h3C);

        // Start-bit glitch rejected, then a good frame.
        @(posedge lpc_clk); #1 uart_rx = 1'b0;
        repeat (3) @(posedge lpc_clk);
        #1 uart_rx = 1'b1;
        repeat (2 * D) @(posedge lpc_clk);
        send_rx(8'hF0, 1'b1, 1'b0);
        repeat (6) @(posedge lpc_clk); #1;
        check("lit_rx_0xf0", rx_data, 8'hF0);

        // Held break gives no bytes; after release a single frame arrives.
        @(posedge lpc_clk); #1 uart_rx = 1'b0;
        repeat (30 * D) @(posedge lpc_clk);
        #1 uart_rx = 1'b1;
        repeat (2 * D) @(posedge lpc_clk);
        send_rx(8'h81, 1'b1, 1'b0);
        repeat (6) @(posedge lpc_clk); #1;
        check("lit_rx_0x81", rx_data, 8'h81);

`ifdef UART_PARITY_EN
        // 0x07 needs parity 1; sending 0 must be dropped silently.
        send_rx(8'h07, 1'b1, 1'b1);
        repeat (6) @(posedge lpc_clk); #1;
        check("lit_rx_par_drop", rx_data, 8'h81);
`endif

        // Reset mid-TX and mid-RX, with valid held high across reset.
        @(posedge lpc_clk); #1;
        tx_data = 8'hFF;
        tx_data_valid = 1'b1;
        uart_rx = 1'b0;
        repeat (3 * D) @(posedge lpc_clk);
        #2;
        lpc_rst = 1'b1;
        uart_rx = 1'b1;
        m_rx_last = 8'h00;
        rxq.delete();
        #1;
        check("rst_async_uart_tx", uart_tx, 1);
        check("rst_async_tx_busy", tx_busy, 0);
        check("rst_async_rx_valid", rx_data_valid, 0);
        check("rst_async_rx_data", rx_data, 0);
        repeat (3) @(posedge lpc_clk);
        #1 lpc_rst = 1'b0;
        repeat (5) @(posedge lpc_clk);
        #1 check("held_valid_not_accepted", tx_busy, 0);
        tx_data_valid = 1'b0;
        send_tx(8'h12, 1);
        wait_tx_idle();

        // Randomized traffic on both paths at once.
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    repeat ($urandom_range(0, NB * D)) @(posedge lpc_clk);
                    send_tx(8'($urandom), $urandom_range(1, 4));
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    bit bad_stop;
                    bit bad_par;
                    bad_stop = ($urandom_range(0, 7) == 0);
                    bad_par  = ($urandom_range(0, 7) == 0);
                    send_rx(8'($urandom), !bad_stop, bad_par);
                    if (bad_stop) repeat (D) @(posedge lpc_clk);
                    else repeat ($urandom_range(0, D)) @(posedge lpc_clk);
                end
            end
        join
        wait_tx_idle();
        repeat (2 * NB * D) @(posedge lpc_clk);
        #1 check("rx_queue_drained", rxq.size(), 0);
        bc = n_cmp;
        check("enough_compares", bc > 12, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- 8N1 UART transceiver sitting directly downstream of the LPC slave, on the same LPC clock.
- Serialises each byte the LPC block produces on tx_data/tx_data_valid onto uart_tx.
- Deserialises uart_rx into one-cycle rx_data/rx_data_valid pulses that the LPC block buffers.
- Drives tx_busy, which the LPC block reports in its line-status read.

Parameters:
DIVISOR, 289, lpc_clk cycles per bit (33.33 MHz / 115200); legal range 4..65535; counters are 16 bits.

Ports:
lpc_clk  input  1  LPC clock; all logic on rising edge
lpc_rst  input  1  reset; asynchronous, active-high
tx_data  input  8  byte to transmit; sampled on accept
tx_data_valid  input  1  level from LPC block; may stay high for several cycles per byte
tx_busy  output  1  high while a TX frame is in progress
rx_data  output  8  last received byte
rx_data_valid  output  1  one-cycle pulse per good received byte
uart_tx  output  1  serial out, idle high
uart_rx  input  1  serial in, asynchronous to lpc_clk

Behaviour:
Reset (asynchronous, while lpc_rst=1):
- uart_tx=1, tx_busy=0, rx_data=0, rx_data_valid=0.
- Both FSMs go to IDLE and all counters clear.
- The uart_rx synchroniser flops and the tx_data_valid edge register are set to 1. A valid held high across reset is therefore not accepted.
- Reset mid-frame aborts the frame immediately: uart_tx returns to 1 asynchronously.

TX accept:
- Accept on the rising edge of tx_data_valid (registered previous value is 0, current value is 1) while tx_busy=0.
- tx_data is latched that same cycle.
- A rising edge while tx_busy=1 is dropped. No queueing is done.
- A held-high valid never retriggers.

TX FSM (IDLE, START, DATA, STOP):
- IDLE -> START on accept. tx_busy=1 and uart_tx=0 from the next cycle.
- Each state lasts exactly DIVISOR cycles.
- DATA shifts 8 bits, LSB first, using a 3-bit index.
- STOP drives 1 for DIVISOR cycles, then returns to IDLE. tx_busy falls on the cycle uart_tx has completed the stop bit.
- Frame length is 10*DIVISOR cycles from the first start-bit cycle to tx_busy=0.
- A new accept is possible the cycle after tx_busy falls. Back-to-back frames have no extra idle.

RX path:
- uart_rx passes through a 2-flop synchroniser (reset value 1) before any use.

RX FSM (IDLE, START, DATA, STOP, WAIT_HIGH):
- IDLE -> START when the synchronised line is 0.
- START waits DIVISOR/2 cycles (integer division), then samples the line:
  - 0 -> DATA.
  - 1 -> IDLE (glitch rejected).
- DATA samples every DIVISOR cycles, 8 samples, LSB first, into a shift register.
- STOP samples after DIVISOR cycles:
  - 1 -> rx_data updates with the shifted byte and rx_data_valid=1 for exactly one cycle, then IDLE.
  - 0 -> framing error: no pulse, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH -> IDLE once the line is seen 1. This prevents a held break from being parsed as repeated 0x00 bytes.

Independence:
- TX and RX are fully independent and may run simultaneously.
- rx_data_valid has no backpressure. The consumer must take it in that cycle.

Optional Feature:
UART_PARITY_EN
- Defined: an even-parity bit follows data bit 7 on both paths, and TX frame length becomes 11*DIVISOR.
  - TX: the parity bit is the XOR of the 8 data bits.
  - RX: the parity bit is sampled one bit period after bit 7. On mismatch, the byte is dropped silently (no pulse, rx_data unchanged), but the stop bit is still sampled and handled as in the RX FSM.
- Undefined: plain 8N1 exactly as above. No parity logic is generated.

Test Plan:
- DIVISOR=8; pulse tx_data_valid high 3 cycles with tx_data=0x55 -> uart_tx shows 0,1,0,1,0,1,0,1,0,1 (8 cycles each); tx_busy high for exactly 80 cycles; exactly one frame sent.
- Raise tx_data_valid with 0xA3 while tx_busy=1 from a 0x41 frame -> only 0x41 is transmitted; next rising edge after tx_busy falls sends its byte.
- Drive uart_rx with an 8N1 frame of 0x3C at DIVISOR=8 -> one rx_data_valid pulse with rx_data=0x3C about 2 cycles after the stop-bit sample point; no other pulses.
- uart_rx low pulse of 3 cycles -> no rx_data_valid, FSM back in IDLE; a following valid 0xF0 frame is received correctly.
- uart_rx held 0 for 30 bit times -> no rx_data_valid (framing error); release to 1, then send 0x81 -> single pulse, rx_data=0x81.
- Assert lpc_rst mid-TX of 0xFF and mid-RX -> uart_tx=1 and tx_busy=0 immediately, no rx_data_valid; after release a new 0x12 transmits as a clean frame. With UART_PARITY_EN, 0x12 carries parity bit 0, and an RX frame of 0x07 with parity bit 0 gives no pulse.
